// File: rtl/pipe_ctrl_pkg.sv
// Shared decode definitions for pipe_decode_ctrl: MIPS opcode/funct
// encodings, ALUOp and Jump codes, the ID/EX control bundle, the
// destination-history entry and the instruction decode function.
package pipe_ctrl_pkg;

   // Primary opcodes (instr[31:26])
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // R-type function codes (instr[5:0])
   localparam logic [5:0] F_SLL  = 6'h00;
   localparam logic [5:0] F_SRL  = 6'h02;
   localparam logic [5:0] F_SRA  = 6'h03;
   localparam logic [5:0] F_JR   = 6'h08;
   localparam logic [5:0] F_ADD  = 6'h20;
   localparam logic [5:0] F_ADDU = 6'h21;
   localparam logic [5:0] F_SUB  = 6'h22;
   localparam logic [5:0] F_SUBU = 6'h23;
   localparam logic [5:0] F_AND  = 6'h24;
   localparam logic [5:0] F_OR   = 6'h25;
   localparam logic [5:0] F_NOR  = 6'h27;
   localparam logic [5:0] F_SLT  = 6'h2A;

   typedef enum logic [3:0] {
      ALU_NONE = 4'b0000,
      ALU_ADD  = 4'b0001,
      ALU_SUB  = 4'b0010,
      ALU_AND  = 4'b0011,
      ALU_OR   = 4'b0100,
      ALU_NOR  = 4'b0101,
      ALU_SLT  = 4'b0110,
      ALU_SLL  = 4'b0111,
      ALU_SRL  = 4'b1000,
      ALU_SRA  = 4'b1001,
      ALU_ADDU = 4'b1010,
      ALU_SUBU = 4'b1011,
      ALU_LUI  = 4'b1100
   } alu_op_e;

   typedef enum logic [1:0] {
      JMP_NONE = 2'b00,
      JMP_DIR  = 2'b01,
      JMP_REG  = 2'b10
   } jump_e;

   // The bundle that is registered into the EX slot
   typedef struct packed {
      logic       valid;
      logic       reg_write;
      logic       mem_to_reg;
      logic       mem_read;
      logic       mem_write;
      logic       branch;
      logic       branch_ne;
      logic       reg_dst;
      logic       alu_src;
      alu_op_e    alu_op;
      jump_e      jump;
      logic       link;
      logic [4:0] dest;
   } bundle_t;

   // Decoder result: the bundle plus ID-stage-only hazard information
   typedef struct packed {
      bundle_t bundle;
      logic    uses_rt;
      logic    is_jr;
      logic    illegal;
   } decode_t;

   // One in-flight writer record
   typedef struct packed {
      logic       valid;
      logic       wr;
      logic       ld;
      logic [4:0] rd;
   } hist_t;

   // Decode one instruction; unknown encodings return an all-zero bundle
   // with only the illegal flag raised.
   function automatic decode_t decode_instr(input logic [5:0] opcode,
                                            input logic [5:0] funct,
                                            input logic [4:0] rt,
                                            input logic [4:0] rd);
      decode_t c;
      logic    known;
      c     = '0;
      known = 1'b1;
      case (opcode)
         OP_RTYPE: begin
            c.bundle.reg_write = 1'b1;
            c.bundle.reg_dst   = 1'b1;
            c.uses_rt          = 1'b1;
            case (funct)
               F_SLL: begin
                  c.bundle.alu_op    = ALU_SLL;
                  // sll $0,... is the canonical nop
                  c.bundle.reg_write = (rd != 5'd0);
               end
               F_SRL:  c.bundle.alu_op = ALU_SRL;
               F_SRA:  c.bundle.alu_op = ALU_SRA;
               F_ADD:  c.bundle.alu_op = ALU_ADD;
               F_ADDU: c.bundle.alu_op = ALU_ADDU;
               F_SUB:  c.bundle.alu_op = ALU_SUB;
               F_SUBU: c.bundle.alu_op = ALU_SUBU;
               F_AND:  c.bundle.alu_op = ALU_AND;
               F_OR:   c.bundle.alu_op = ALU_OR;
               F_NOR:  c.bundle.alu_op = ALU_NOR;
               F_SLT:  c.bundle.alu_op = ALU_SLT;
               F_JR: begin
                  c.bundle.reg_write = 1'b0;
                  c.bundle.reg_dst   = 1'b0;
                  c.uses_rt          = 1'b0;
                  c.bundle.jump      = JMP_REG;
                  c.is_jr            = 1'b1;
               end
               default: known = 1'b0;
            endcase
         end
         OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_SLTI, OP_LUI: begin
            c.bundle.alu_src   = 1'b1;
            c.bundle.reg_write = 1'b1;
            case (opcode)
               OP_ADDI:  c.bundle.alu_op = ALU_ADD;
               OP_ADDIU: c.bundle.alu_op = ALU_ADDU;
               OP_ANDI:  c.bundle.alu_op = ALU_AND;
               OP_ORI:   c.bundle.alu_op = ALU_OR;
               OP_SLTI:  c.bundle.alu_op = ALU_SLT;
               default:  c.bundle.alu_op = ALU_LUI;
            endcase
         end
         OP_LW: begin
            c.bundle.alu_src    = 1'b1;
            c.bundle.alu_op     = ALU_ADDU;
            c.bundle.mem_read   = 1'b1;
            c.bundle.mem_to_reg = 1'b1;
            c.bundle.reg_write  = 1'b1;
         end
         OP_SW: begin
            c.bundle.alu_src   = 1'b1;
            c.bundle.alu_op    = ALU_ADDU;
            c.bundle.mem_write = 1'b1;
            c.uses_rt          = 1'b1;
         end
         OP_BEQ, OP_BNE: begin
            c.bundle.branch    = 1'b1;
            c.bundle.branch_ne = (opcode == OP_BNE);
            c.bundle.alu_op    = ALU_SUBU;
            c.uses_rt          = 1'b1;
         end
         OP_J: c.bundle.jump = JMP_DIR;
         OP_JAL: begin
            c.bundle.jump      = JMP_DIR;
            c.bundle.link      = 1'b1;
            c.bundle.reg_write = 1'b1;
         end
         default: known = 1'b0;
      endcase

      if (c.bundle.link)
         c.bundle.dest = 5'd31;
      else if (c.bundle.reg_dst)
         c.bundle.dest = rd;
      else
         c.bundle.dest = rt;

      if (known) begin
         c.bundle.valid = 1'b1;
      end else begin
         c         = '0;
         c.illegal = 1'b1;
      end
      return c;
   endfunction

endpackage

// File: rtl/dest_hist_shift.sv
// Shift register of in-flight destination records. Entry 0 is the EX
// stage, higher entries are older. hold freezes every entry; bubble loads
// an invalid record into entry 0 while the rest still shift.
module dest_hist_shift
   import pipe_ctrl_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 hold,
   input  logic                 bubble,
   input  hist_t                entry,
   output hist_t [DEPTH-1:0]    hist
);

   hist_t hist_reg [DEPTH];

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_stage
         if (gi == 0) begin : g_head
            // Head entry: capture the newly decoded record or a bubble
            always_ff @(posedge clk) begin
               if (!rst_n)
                  hist_reg[0] <= '0;
               else if (!hold)
                  hist_reg[0] <= bubble ? '0 : entry;
            end
         end else begin : g_tail
            // Older entries: age by one stage
            always_ff @(posedge clk) begin
               if (!rst_n)
                  hist_reg[gi] <= '0;
               else if (!hold)
                  hist_reg[gi] <= hist_reg[gi-1];
            end
         end
         assign hist[gi] = hist_reg[gi];
      end
   endgenerate

endmodule

// File: rtl/pipe_decode_ctrl.sv
// Registered, hazard-aware MIPS main decoder. Produces the ID/EX control
// bundle one cycle after the instruction, tracks HIST_DEPTH in-flight
// writers, and derives load-use stalls and the jr forwarding select.
// Optional macro PIPE_DECODE_ILLEGAL_TRAP_EN adds illegal_instr/illegal_cnt.
// HIST_DEPTH must lie in 1..4.
module pipe_decode_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int HIST_DEPTH = 2,
   parameter int ALUOP_W    = 4,
   parameter int SEL_W      = $clog2(HIST_DEPTH + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               valid_in,
   input  logic [5:0]         opcode,
   input  logic [5:0]         funct,
   input  logic [4:0]         rs,
   input  logic [4:0]         rt,
   input  logic [4:0]         rd,
   input  logic               stall_in,
   input  logic               flush,
   output logic               load_use_stall,
   output logic [SEL_W-1:0]   jr_fwd_sel,
   output logic               valid_out,
   output logic               RegWrite,
   output logic               MemToReg,
   output logic               MemRead,
   output logic               MemWrite,
   output logic               Branch,
   output logic               RegDst,
   output logic               ALUSrc,
   output logic               BranchNe,
   output logic [ALUOP_W-1:0] ALUOp,
   output logic [1:0]         Jump,
   output logic               Link,
`ifdef PIPE_DECODE_ILLEGAL_TRAP_EN
   output logic               illegal_instr,
   output logic [7:0]         illegal_cnt,
`endif
   output logic [4:0]         dest_reg
);

   decode_t                  dec;
   hist_t                    hist_entry;
   hist_t [HIST_DEPTH-1:0]   hist;
   logic  [HIST_DEPTH-1:0]   rs_match;
   logic  [SEL_W-1:0]        jr_sel;
   logic                     bubble;
   bundle_t                  ctrl_reg;
   bundle_t                  ctrl_next;

   // Decode the presented instruction; no valid_in means a bubble
   always_comb begin
      dec = '0;
      if (valid_in)
         dec = decode_instr(opcode, funct, rt, rd);
   end

   // History record for the instruction entering EX; $0 writes are not writers
   always_comb begin
      hist_entry       = '0;
      hist_entry.valid = dec.bundle.valid;
      hist_entry.wr    = dec.bundle.reg_write & (dec.bundle.dest != 5'd0);
      hist_entry.ld    = dec.bundle.mem_read;
      hist_entry.rd    = dec.bundle.dest;
   end

   // Load in EX whose result the ID instruction reads: hold IF/ID one cycle
   always_comb begin
      load_use_stall = valid_in & ~flush & hist[0].valid & hist[0].ld &
                       (hist[0].rd != 5'd0) &
                       ((rs == hist[0].rd) | (dec.uses_rt & (rt == hist[0].rd)));
   end

   assign bubble = flush | load_use_stall;

   dest_hist_shift #(
      .DEPTH (HIST_DEPTH)
   ) u_hist (
      .clk    (clk),
      .rst_n  (rst_n),
      .hold   (stall_in),
      .bubble (bubble),
      .entry  (hist_entry),
      .hist   (hist)
   );

   genvar gi;
   generate
      for (gi = 0; gi < HIST_DEPTH; gi++) begin : g_match
         assign rs_match[gi] = hist[gi].valid & hist[gi].wr & (hist[gi].rd == rs);
      end
   endgenerate

   // jr forwarding: youngest matching writer wins; a load in EX stalls instead
   always_comb begin
      jr_sel = '0;
      if (dec.is_jr && (rs != 5'd0)) begin
         for (int k = HIST_DEPTH - 1; k >= 0; k--) begin
            if (rs_match[k])
               jr_sel = SEL_W'(k + 1);
         end
         if (rs_match[0] && hist[0].ld)
            jr_sel = '0;
      end
   end

   assign jr_fwd_sel = jr_sel;

   // Next EX bundle: freeze on stall_in, bubble on flush/hazard/unknown
   always_comb begin
      ctrl_next = ctrl_reg;
      if (!stall_in) begin
         if (bubble || dec.illegal)
            ctrl_next = '0;
         else
            ctrl_next = dec.bundle;
      end
   end

   // EX-slot control register
   always_ff @(posedge clk) begin
      if (!rst_n)
         ctrl_reg <= '0;
      else
         ctrl_reg <= ctrl_next;
   end

`ifdef PIPE_DECODE_ILLEGAL_TRAP_EN
   logic       illegal_reg;
   logic       illegal_next;
   logic [7:0] illegal_cnt_reg;

   assign illegal_next = valid_in & ~flush & ~stall_in & ~load_use_stall & dec.illegal;

   // One-cycle illegal pulse and saturating occurrence counter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         illegal_reg     <= 1'b0;
         illegal_cnt_reg <= 8'd0;
      end else begin
         illegal_reg <= illegal_next;
         if (illegal_next && (illegal_cnt_reg != 8'hFF))
            illegal_cnt_reg <= illegal_cnt_reg + 8'd1;
      end
   end

   assign illegal_instr = illegal_reg;
   assign illegal_cnt   = illegal_cnt_reg;
`endif

   assign valid_out = ctrl_reg.valid;
   assign RegWrite  = ctrl_reg.reg_write;
   assign MemToReg  = ctrl_reg.mem_to_reg;
   assign MemRead   = ctrl_reg.mem_read;
   assign MemWrite  = ctrl_reg.mem_write;
   assign Branch    = ctrl_reg.branch;
   assign BranchNe  = ctrl_reg.branch_ne;
   assign RegDst    = ctrl_reg.reg_dst;
   assign ALUSrc    = ctrl_reg.alu_src;
   assign ALUOp     = ALUOP_W'(ctrl_reg.alu_op);
   assign Jump      = ctrl_reg.jump;
   assign Link      = ctrl_reg.link;
   assign dest_reg  = ctrl_reg.dest;

endmodule

// File: tb/tb_pipe_decode_ctrl.sv
// Directed testbench for pipe_decode_ctrl (HIST_DEPTH=2, ALUOP_W=4).
// Define PIPE_DECODE_ILLEGAL_TRAP_EN to also exercise the illegal trap.
module tb_pipe_decode_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       valid_in;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic [4:0] rs;
   logic [4:0] rt;
   logic [4:0] rd;
   logic       stall_in;
   logic       flush;
   logic       load_use_stall;
   logic [1:0] jr_fwd_sel;
   logic       valid_out;
   logic       RegWrite, MemToReg, MemRead, MemWrite, Branch, RegDst, ALUSrc;
   logic       BranchNe;
   logic [3:0] ALUOp;
   logic [1:0] Jump;
   logic       Link;
   logic [4:0] dest_reg;
`ifdef PIPE_DECODE_ILLEGAL_TRAP_EN
   logic       illegal_instr;
   logic [7:0] illegal_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   pipe_decode_ctrl #(
      .HIST_DEPTH (2),
      .ALUOP_W    (4),
      .SEL_W      (2)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .valid_in       (valid_in),
      .opcode         (opcode),
      .funct          (funct),
      .rs             (rs),
      .rt             (rt),
      .rd             (rd),
      .stall_in       (stall_in),
      .flush          (flush),
      .load_use_stall (load_use_stall),
      .jr_fwd_sel     (jr_fwd_sel),
      .valid_out      (valid_out),
      .RegWrite       (RegWrite),
      .MemToReg       (MemToReg),
      .MemRead        (MemRead),
      .MemWrite       (MemWrite),
      .Branch         (Branch),
      .RegDst         (RegDst),
      .ALUSrc         (ALUSrc),
      .BranchNe       (BranchNe),
      .ALUOp          (ALUOp),
      .Jump           (Jump),
      .Link           (Link),
`ifdef PIPE_DECODE_ILLEGAL_TRAP_EN
      .illegal_instr  (illegal_instr),
      .illegal_cnt    (illegal_cnt),
`endif
      .dest_reg       (dest_reg)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Present one instruction in ID and let combinational outputs settle
   task automatic drive(input string name, input logic [5:0] op, input logic [5:0] fn,
                        input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
      valid_in = 1'b1;
      opcode   = op;
      funct    = fn;
      rs       = s;
      rt       = t;
      rd       = d;
      #1;
      $display("t=%0t present %s", $time, name);
   endtask

   task automatic idle();
      valid_in = 1'b0;
      opcode   = '0;
      funct    = '0;
      rs       = '0;
      rt       = '0;
      rd       = '0;
      #1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n    = 1'b0;
      stall_in = 1'b0;
      flush    = 1'b0;
      idle();
      repeat (2) step();

      // Reset state
      check_val("rst valid_out", valid_out, 0);
      check_val("rst RegWrite", RegWrite, 0);
      check_val("rst ALUOp", ALUOp, 0);
      check_val("rst dest_reg", dest_reg, 0);
      check_val("rst lus", load_use_stall, 0);
      check_val("rst jr_sel", jr_fwd_sel, 0);
`ifdef PIPE_DECODE_ILLEGAL_TRAP_EN
      check_val("rst illegal_cnt", illegal_cnt, 0);
`endif
      rst_n = 1'b1;
      step();

      // lw $8,0($9) then add $10,$8,$11: one-cycle load-use stall
      drive("lw $8,0($9)", 6'h23, 6'h00, 5'd9, 5'd8, 5'd0);
      check_val("lw lus", load_use_stall, 0);
      step();
      check_val("lw MemRead", MemRead, 1);
      check_val("lw MemToReg", MemToReg, 1);
      check_val("lw RegWrite", RegWrite, 1);
      check_val("lw ALUSrc", ALUSrc, 1);
      check_val("lw ALUOp", ALUOp, 4'b1010);
      check_val("lw dest", dest_reg, 8);
      drive("add $10,$8,$11", 6'h00, 6'h20, 5'd8, 5'd11, 5'd10);
      check_val("add lus on", load_use_stall, 1);
      step();
      check_val("stall bubble valid", valid_out, 0);
      check_val("stall bubble RegWrite", RegWrite, 0);
      check_val("add lus off", load_use_stall, 0);
      step();
      check_val("add valid", valid_out, 1);
      check_val("add RegWrite", RegWrite, 1);
      check_val("add RegDst", RegDst, 1);
      check_val("add ALUOp", ALUOp, 4'b0001);
      check_val("add dest", dest_reg, 10);

      // addi $5,$0,3 then jr $5: forward from EX
      drive("addi $5,$0,3", 6'h08, 6'h00, 5'd0, 5'd5, 5'd0);
      step();
      check_val("addi ALUSrc", ALUSrc, 1);
      check_val("addi ALUOp", ALUOp, 4'b0001);
      check_val("addi dest", dest_reg, 5);
      drive("jr $5", 6'h00, 6'h08, 5'd5, 5'd0, 5'd0);
      check_val("jr ex sel", jr_fwd_sel, 1);
      check_val("jr ex lus", load_use_stall, 0);
      step();
      check_val("jr Jump", Jump, 2'b10);
      check_val("jr RegWrite", RegWrite, 0);

      // addi $5, nop, jr $5: forward from MEM
      drive("addi $5,$0,3", 6'h08, 6'h00, 5'd0, 5'd5, 5'd0);
      step();
      drive("nop", 6'h00, 6'h00, 5'd0, 5'd0, 5'd0);
      step();
      check_val("nop RegWrite", RegWrite, 0);
      check_val("nop valid", valid_out, 1);
      drive("jr $5", 6'h00, 6'h08, 5'd5, 5'd0, 5'd0);
      check_val("jr mem sel", jr_fwd_sel, 2);
      step();

      // jr $0 after a writer never forwards
      drive("addi $7,$0,1", 6'h08, 6'h00, 5'd0, 5'd7, 5'd0);
      step();
      drive("jr $0", 6'h00, 6'h08, 5'd0, 5'd0, 5'd0);
      check_val("jr0 sel", jr_fwd_sel, 0);
      step();

      // lw $12 then jr $12: stall with select 0, then forward from MEM
      drive("lw $12,0($0)", 6'h23, 6'h00, 5'd0, 5'd12, 5'd0);
      step();
      drive("jr $12", 6'h00, 6'h08, 5'd12, 5'd0, 5'd0);
      check_val("jr ld lus", load_use_stall, 1);
      check_val("jr ld sel", jr_fwd_sel, 0);
      step();
      check_val("jr ld bubble", valid_out, 0);
      check_val("jr ld sel after", jr_fwd_sel, 2);
      check_val("jr ld lus after", load_use_stall, 0);
      step();
      check_val("jr ld Jump", Jump, 2'b10);

      // jal
      drive("jal", 6'h03, 6'h00, 5'd0, 5'd0, 5'd0);
      step();
      check_val("jal Jump", Jump, 2'b01);
      check_val("jal Link", Link, 1);
      check_val("jal dest", dest_reg, 31);
      check_val("jal RegWrite", RegWrite, 1);

      // Flushed sw becomes a bubble
      flush = 1'b1;
      drive("sw $3,0($2) flushed", 6'h2B, 6'h00, 5'd2, 5'd3, 5'd0);
      step();
      check_val("flush MemWrite", MemWrite, 0);
      check_val("flush valid", valid_out, 0);
      flush = 1'b0;

      // Unflushed sw
      drive("sw $3,0($2)", 6'h2B, 6'h00, 5'd2, 5'd3, 5'd0);
      step();
      check_val("sw MemWrite", MemWrite, 1);
      check_val("sw RegWrite", RegWrite, 0);
      check_val("sw ALUOp", ALUOp, 4'b1010);

      // addi $6, beq, then stall_in for 3 cycles (one also flushed)
      drive("addi $6,$0,1", 6'h08, 6'h00, 5'd0, 5'd6, 5'd0);
      step();
      drive("beq $1,$2", 6'h04, 6'h00, 5'd1, 5'd2, 5'd0);
      step();
      check_val("beq Branch", Branch, 1);
      check_val("beq BranchNe", BranchNe, 0);
      check_val("beq ALUOp", ALUOp, 4'b1011);
      check_val("beq ALUSrc", ALUSrc, 0);
      stall_in = 1'b1;
      drive("jr $6 (stalled)", 6'h00, 6'h08, 5'd6, 5'd0, 5'd0);
      check_val("stall sel pre", jr_fwd_sel, 2);
      for (int i = 0; i < 3; i++) begin
         flush = (i == 1);
         step();
         check_val("stall hold Branch", Branch, 1);
         check_val("stall hold ALUOp", ALUOp, 4'b1011);
         check_val("stall hold valid", valid_out, 1);
         check_val("stall hold Jump", Jump, 0);
         check_val("stall hist sel", jr_fwd_sel, 2);
      end
      stall_in = 1'b0;
      flush    = 1'b0;
      step();
      check_val("post stall Jump", Jump, 2'b10);
      check_val("post stall valid", valid_out, 1);

      // bne
      drive("bne $1,$2", 6'h05, 6'h00, 5'd1, 5'd2, 5'd0);
      step();
      check_val("bne Branch", Branch, 1);
      check_val("bne BranchNe", BranchNe, 1);

      // Unknown opcode is a bubble
      drive("opcode 111111", 6'h3F, 6'h00, 5'd1, 5'd2, 5'd3);
      step();
      check_val("unk valid", valid_out, 0);
      check_val("unk RegWrite", RegWrite, 0);
      check_val("unk Branch", Branch, 0);
`ifdef PIPE_DECODE_ILLEGAL_TRAP_EN
      check_val("unk illegal", illegal_instr, 1);
      check_val("unk cnt", illegal_cnt, 1);
`endif

      // Reset during a stall clears everything
      drive("lw $8,0($9)", 6'h23, 6'h00, 5'd9, 5'd8, 5'd0);
      step();
      stall_in = 1'b1;
      drive("add $10,$8,$11", 6'h00, 6'h20, 5'd8, 5'd11, 5'd10);
      check_val("rst stall lus", load_use_stall, 1);
      rst_n = 1'b0;
      step();
      check_val("rst mid valid", valid_out, 0);
      check_val("rst mid RegWrite", RegWrite, 0);
      check_val("rst mid MemRead", MemRead, 0);
      check_val("rst mid dest", dest_reg, 0);
      check_val("rst mid ALUOp", ALUOp, 0);
      check_val("rst mid lus", load_use_stall, 0);
`ifdef PIPE_DECODE_ILLEGAL_TRAP_EN
      check_val("rst mid cnt", illegal_cnt, 0);
`endif
      rst_n    = 1'b1;
      stall_in = 1'b0;
      idle();
      step();

`ifdef PIPE_DECODE_ILLEGAL_TRAP_EN
      // 300 illegal encodings: pulse every time, counter saturates at 255
      valid_in = 1'b1;
      opcode   = 6'h3F;
      #1;
      $display("t=%0t present opcode 111111 x300", $time);
      for (int i = 0; i < 300; i++) begin
         step();
         check_val("trap pulse", illegal_instr, 1);
         if (i == 9)   check_val("trap cnt 10", illegal_cnt, 10);
         if (i == 254) check_val("trap cnt 255", illegal_cnt, 255);
      end
      check_val("trap cnt hold", illegal_cnt, 255);
      idle();
      step();
      check_val("trap pulse off", illegal_instr, 0);
      check_val("trap cnt final", illegal_cnt, 255);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_decode_ctrl.md
Name: pipe_decode_ctrl

Overview:
- Registered, hazard-aware successor to the combinational main decoder.
- Decodes R-type, I-type and J-type MIPS instructions into the ID/EX control bundle, one cycle after the instruction is presented.
- Keeps a HIST_DEPTH-deep history of in-flight destination registers.
- From that history it generates load-use stalls and the JR forwarding select.

Parameters:
- HIST_DEPTH, 2: in-flight writer stages tracked (entry 0 = EX, 1 = MEM, ...); legal range 1..4.
- ALUOP_W, 4: ALUOp width; ALUOP_W > 4 zero-extends the codes below.
- SEL_W, $clog2(HIST_DEPTH+1): width of jr_fwd_sel.

Ports:
- clk  in  1  clock; reset is synchronous and active-low.
- rst_n  in  1  synchronous active-low reset.
- valid_in  in  1  an instruction is presented in ID.
- opcode  in  6  instr[31:26].
- funct  in  6  instr[5:0].
- rs  in  5  instr[25:21].
- rt  in  5  instr[20:16].
- rd  in  5  instr[15:11].
- stall_in  in  1  external freeze from downstream.
- flush  in  1  squash the instruction in ID (branch/jump taken).
- load_use_stall  out  1  combinational; upstream holds IF/ID.
- jr_fwd_sel  out  SEL_W  combinational; 0 = register file, k = forward from history entry k-1.
- valid_out  out  1  registered; EX slot holds a real instruction.
- RegWrite, MemToReg, MemRead, MemWrite, Branch, RegDst, ALUSrc  out  1 each  registered.
- BranchNe  out  1  registered; 1 = bne, 0 = beq.
- ALUOp  out  ALUOP_W  registered.
- Jump  out  2  registered; 00 none, 01 j/jal, 10 jr.
- Link  out  1  registered; jal writes PC+8 to $31.
- dest_reg  out  5  registered; resolved write register.

Behaviour:
- Reset (rst_n=0 at posedge): all registered outputs 0, all history entries invalid. Combinational outputs are 0 while the history is invalid.
- Latency: 1 cycle from valid_in to the registered bundle.
- Update priority at each posedge: reset > stall_in (hold bundle and history) > flush or load_use_stall (load a bubble: all controls 0, valid_out 0, history shifts in an invalid entry) > normal (load the decoded bundle, history shifts).
- Decoded bundle for an invalid or unknown opcode/funct is a bubble.
- ALUOp codes: none 0000, add 0001, sub 0010, and 0011, or 0100, nor 0101, slt 0110, sll 0111, srl 1000, sra 1001, addu 1010, subu 1011, lui 1100.
- R-type (opcode 0):
  - add, addu, sub, subu, and, or, nor, slt, sll, srl, sra: RegWrite=1, RegDst=1, matching ALUOp.
  - jr (funct 001000): Jump=10, RegWrite=0.
  - funct 0 with rd=0 (nop): RegWrite=0.
- I-type: ALUSrc=1, RegDst=0.
  - addi 0001, addiu 1010, andi 0011, ori 0100, slti 0110, lui 1100, each with RegWrite=1.
  - lw: 1010, MemRead=1, MemToReg=1, RegWrite=1.
  - sw: 1010, MemWrite=1.
  - beq/bne: ALUSrc=0, Branch=1, ALUOp 1011, BranchNe per opcode.
- J-type: j gives Jump=01. jal gives Jump=01, Link=1, RegWrite=1, dest_reg=31.
- dest_reg: rd if RegDst, 31 if Link, else rt. Any RegWrite with dest 0 is recorded in history as a non-writer.
- History entry fields: {valid, wr, ld, rd}. Entry 0 is loaded from the decoded bundle; entry k comes from entry k-1.
- load_use_stall = valid_in & !flush & hist[0].valid & hist[0].ld & hist[0].rd≠0 & (rs==hist[0].rd | (uses_rt & rt==hist[0].rd)).
  - uses_rt is 1 for R-type ALU ops, sw, beq and bne.
- jr_fwd_sel: for jr only, k = 1 + index of the youngest valid writer whose rd == rs. 0 if there is no match, or if rs == 0.
  - A youngest match that is a load in entry 0 raises load_use_stall instead; jr_fwd_sel is then 0.
- Simultaneous flush and stall_in: stall_in wins; the flush must be reasserted.
- Reset mid-stall: clears everything; load_use_stall drops the next cycle.

Optional Feature:
- Macro: PIPE_DECODE_ILLEGAL_TRAP_EN.
- When defined:
  - Adds output illegal_instr (registered, 1 bit): set for one cycle when a valid, unflushed, unstalled unknown encoding is decoded.
  - Adds output illegal_cnt (registered, 8 bits, saturating at 255, cleared by reset).
- When undefined: neither port exists, and unknown encodings silently become bubbles.

Decomposition:
- Package pipe_ctrl_pkg: opcode/funct localparams, ALUOp codes, Jump codes, and the control-bundle struct typedef.
- Sub-module dest_hist_shift: HIST_DEPTH history shift register with hold/bubble controls and a parallel read-out.

Test Plan:
- lw $8,0($9), then add $10,$8,$11: load_use_stall=1 for exactly 1 cycle; EX gets a bubble; add then issues with RegWrite=1, ALUOp=0001, dest_reg=10.
- addi $5,$0,3, then jr $5: jr_fwd_sel=1, Jump=10.
- addi $5, nop, jr $5 with HIST_DEPTH=2: jr_fwd_sel=2.
- jr $0 after any writer: jr_fwd_sel=0.
- jal: Jump=01, Link=1, dest_reg=31, RegWrite=1.
- flush with a valid sw: the next cycle is a bubble (MemWrite=0, valid_out=0).
- stall_in held 3 cycles during a beq: the bundle and history are unchanged.
- rst_n=0 during a stall: all outputs 0 the next cycle.
- With PIPE_DECODE_ILLEGAL_TRAP_EN, opcode 111111 presented 300 times: illegal_instr pulses each time; illegal_cnt reaches 255 and holds.
